// File: rtl/barrel_seq.sv
// barrel_seq: registers rotate commands into a combinational barrel shifter and captures its results.
// Single mode yields one result; sweep mode yields one result per amount 0..WIDTH-1.
module barrel_seq #(
    parameter int WIDTH = 4,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dir,
    input  logic             mode,
    input  logic [SEL_W-1:0] amt,
    input  logic [WIDTH-1:0] data_in,
    output logic             sh_d,
    output logic [SEL_W-1:0] sh_sel,
    output logic [WIDTH-1:0] sh_in,
    input  logic [WIDTH-1:0] sh_out,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [SEL_W-1:0] out_amt,
    output logic             done
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t           state_q;
    logic             mode_q, sh_d_q, busy_q, out_valid_q, done_q;
    logic [SEL_W-1:0] sh_sel_q, out_amt_q;
    logic [WIDTH-1:0] sh_in_q, out_data_q;
    logic             last;
    // A single command, or a sweep at its final amount, finishes this cycle.
    assign last = !mode_q || sh_sel_q == SEL_W'(WIDTH - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            sh_d_q      <= 1'b0;
            sh_sel_q    <= '0;
            sh_in_q     <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_amt_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            if (state_q == IDLE) begin
                if (start) begin
                    sh_in_q  <= data_in;
                    sh_d_q   <= dir;
                    sh_sel_q <= mode ? '0 : amt;
                    mode_q   <= mode;
                    busy_q   <= 1'b1;
                    state_q  <= RUN;
                end
            end else begin
                out_data_q  <= sh_out;
                out_amt_q   <= sh_sel_q;
                out_valid_q <= 1'b1;
                if (last) begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end else begin
                    sh_sel_q <= sh_sel_q + 1'b1;
                end
            end
        end
    end
    assign sh_d      = sh_d_q;
    assign sh_sel    = sh_sel_q;
    assign sh_in     = sh_in_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_amt   = out_amt_q;
    assign done      = done_q;
endmodule

// File: tb/tb_barrel_seq.sv
// tb_barrel_seq: directed bench for barrel_seq with a behavioural 4-bit rotator as the shifter.
module tb_barrel_seq;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, dir = 1'b0, mode = 1'b0;
    logic [1:0] amt = '0, sh_sel, out_amt;
    logic [3:0] data_in = '0, sh_in, sh_out, out_data;
    logic       sh_d, busy, out_valid, done;
    logic [7:0] dbl;
    int         total = 0, passed = 0;

    always #5 clk = ~clk;

    assign dbl    = {sh_in, sh_in};
    assign sh_out = sh_d ? 4'((dbl << sh_sel) >> 4) : 4'(dbl >> sh_sel);

    barrel_seq #(.WIDTH(4), .SEL_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .mode(mode), .amt(amt),
        .data_in(data_in), .sh_d(sh_d), .sh_sel(sh_sel), .sh_in(sh_in), .sh_out(sh_out),
        .busy(busy), .out_valid(out_valid), .out_data(out_data), .out_amt(out_amt), .done(done)
    );

    typedef struct {
        logic [3:0] d;
        logic       dr;
        logic [1:0] a;
        logic [3:0] e;
    } vec_t;
    vec_t v[7];

    task automatic chk(input string n, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", n, act, exp);
    endtask

    task automatic sweep(input logic [3:0] d, input logic dr, input logic [15:0] e, input int poke);
        start = 1'b1; data_in = d; dir = dr; mode = 1'b1; amt = 2'd2;
        @(negedge clk);
        start = 1'b0; data_in = 4'b0000; mode = 1'b0; dir = ~dr;
        chk("sweep busy after accept", int'(busy), 1);
        chk("sweep no early valid", int'(out_valid), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("sweep valid", int'(out_valid), 1);
            chk("sweep data", int'(out_data), int'(e[15-4*i -: 4]));
            chk("sweep amt", int'(out_amt), i);
            chk("sweep done", int'(done), int'(i == 3));
            chk("sweep busy", int'(busy), int'(i != 3));
            start = (i == poke);
            data_in = 4'b1010;
        end
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("sweep quiet valid", int'(out_valid), 0);
            chk("sweep quiet busy", int'(busy), 0);
        end
        chk("sweep holds data", int'(out_data), int'(e[3:0]));
    endtask

    initial begin
        v[0] = '{4'b1100, 1'b0, 2'd1, 4'b0110};
        v[1] = '{4'b1100, 1'b1, 2'd3, 4'b0110};
        v[2] = '{4'b0001, 1'b0, 2'd1, 4'b1000};
        v[3] = '{4'b1011, 1'b1, 2'd1, 4'b0111};
        v[4] = '{4'b1011, 1'b0, 2'd2, 4'b1110};
        v[5] = '{4'b1001, 1'b0, 2'd0, 4'b1001};
        v[6] = '{4'b0110, 1'b1, 2'd2, 4'b1001};

        #12;
        chk("reset busy", int'(busy), 0);
        chk("reset valid", int'(out_valid), 0);
        chk("reset data", int'(out_data), 0);
        chk("reset sh_in", int'(sh_in), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (v[k]) begin
            start = 1'b1; data_in = v[k].d; dir = v[k].dr; mode = 1'b0; amt = v[k].a;
            @(negedge clk);
            start = 1'b0; data_in = ~v[k].d; dir = ~v[k].dr; mode = 1'b1; amt = ~v[k].a;
            chk("single busy", int'(busy), 1);
            chk("single no early valid", int'(out_valid), 0);
            chk("single sh_in", int'(sh_in), int'(v[k].d));
            @(negedge clk);
            chk("single valid", int'(out_valid), 1);
            chk("single done", int'(done), 1);
            chk("single busy low", int'(busy), 0);
            chk("single data", int'(out_data), int'(v[k].e));
            chk("single amt", int'(out_amt), int'(v[k].a));
            @(negedge clk);
            chk("single valid drops", int'(out_valid), 0);
            chk("single data holds", int'(out_data), int'(v[k].e));
        end

        sweep(4'b1100, 1'b0, 16'b1100_0110_0011_1001, -1);
        sweep(4'b1100, 1'b1, 16'b1100_1001_0011_0110, -1);
        sweep(4'b1100, 1'b0, 16'b1100_0110_0011_1001, 1);

        start = 1'b1; data_in = 4'b1100; dir = 1'b0; mode = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre-reset 2nd strobe amt", int'(out_amt), 1);
        rst_n = 1'b0;
        #1;
        chk("async reset valid", int'(out_valid), 0);
        chk("async reset busy", int'(busy), 0);
        chk("async reset data", int'(out_data), 0);
        chk("async reset amt", int'(out_amt), 0);
        chk("async reset sh_sel", int'(sh_sel), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post-reset quiet", int'(out_valid), 0);
        end

        start = 1'b1; data_in = 4'b1100; dir = 1'b1; mode = 1'b0; amt = 2'd3;
        @(negedge clk);
        data_in = 4'b0001; dir = 1'b0; amt = 2'd1;
        chk("b2b busy first", int'(busy), 1);
        @(negedge clk);
        chk("b2b first valid", int'(out_valid), 1);
        chk("b2b first data", int'(out_data), 4'b0110);
        chk("b2b first done", int'(done), 1);
        @(negedge clk);
        start = 1'b0;
        chk("b2b second accepted", int'(busy), 1);
        chk("b2b gap valid", int'(out_valid), 0);
        @(negedge clk);
        chk("b2b second valid", int'(out_valid), 1);
        chk("b2b second data", int'(out_data), 4'b1000);
        chk("b2b second amt", int'(out_amt), 1);
        @(negedge clk);
        chk("b2b end quiet", int'(out_valid), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
